// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// FSM state encoding, requester IDs and performance-counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int PERF_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin pick.
// req_i[0] is the IF requester and req_i[1] is the D requester. On a tie,
// the requester that was not served last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  // Pick the winner from the active requests and the previous grant.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid_o  = |req_i;
    winner_o = REQ_IF;
    unique case (req_i)
      2'b01:   winner_o = REQ_IF;
      2'b10:   winner_o = REQ_D;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = REQ_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port 128x32 read-only memory between the
// instruction-fetch (IF) and data (D) requesters. One access every three
// cycles: grant in IDLE, read in READ, respond in RESP until accepted.
// Optional build macro MEM_ARB_PERF_EN adds saturating grant/conflict
// counters with a synchronous clear input.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int   AW      = 7,
  parameter int   DW      = 32,
  parameter logic RR_INIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          if_rready,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          d_rready,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_if_cnt,
  output logic [PERF_W-1:0] perf_d_cnt,
  output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] rdata_q;
  logic          owner_q;
  logic          last_grant_q;

  logic arb_valid;
  logic arb_winner;
  logic grant;
  logic in_resp;
  logic owner_rready;

  rr_arbiter2 u_rr (
    .req_i        ({d_req, if_req}),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .winner_o     (arb_winner)
  );

  // Grants only ever leave IDLE, and the arbiter names exactly one winner.
  assign grant  = (state_q == IDLE) && arb_valid;
  assign if_gnt = grant && (arb_winner == REQ_IF);
  assign d_gnt  = grant && (arb_winner == REQ_D);

  // The memory always sees the latched address, never a requester's live bus.
  assign mem_addr = addr_q;

  assign in_resp   = (state_q == RESP);
  assign if_rvalid = in_resp && (owner_q == REQ_IF);
  assign d_rvalid  = in_resp && (owner_q == REQ_D);
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign d_rdata   = d_rvalid  ? rdata_q : '0;

  // Only the owner's ready can retire the response.
  assign owner_rready = (owner_q == REQ_D) ? d_rready : if_rready;

  // Sequence one access: latch the winner, read memory, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rdata_q      <= '0;
      owner_q      <= REQ_IF;
      last_grant_q <= RR_INIT;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            addr_q       <= (arb_winner == REQ_D) ? d_addr : if_addr;
            owner_q      <= arb_winner;
            last_grant_q <= arb_winner;
            state_q      <= READ;
          end
        end
        READ: begin
          rdata_q <= mem_data;
          state_q <= RESP;
        end
        RESP: begin
          if (owner_rready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] perf_if_cnt_q, perf_if_cnt_d;
  logic [PERF_W-1:0] perf_d_cnt_q, perf_d_cnt_d;
  logic [PERF_W-1:0] perf_conflict_cnt_q, perf_conflict_cnt_d;

  // Next counter values: clear beats increment, increments saturate.
  always_comb begin
    perf_if_cnt_d       = perf_if_cnt_q;
    perf_d_cnt_d        = perf_d_cnt_q;
    perf_conflict_cnt_d = perf_conflict_cnt_q;
    if (perf_clr) begin
      perf_if_cnt_d       = '0;
      perf_d_cnt_d        = '0;
      perf_conflict_cnt_d = '0;
    end else begin
      if (if_gnt) perf_if_cnt_d = sat_inc(perf_if_cnt_q);
      if (d_gnt)  perf_d_cnt_d  = sat_inc(perf_d_cnt_q);
      if (grant && if_req && d_req) perf_conflict_cnt_d = sat_inc(perf_conflict_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_cnt_q       <= '0;
      perf_d_cnt_q        <= '0;
      perf_conflict_cnt_q <= '0;
    end else begin
      perf_if_cnt_q       <= perf_if_cnt_d;
      perf_d_cnt_q        <= perf_d_cnt_d;
      perf_conflict_cnt_q <= perf_conflict_cnt_d;
    end
  end

  assign perf_if_cnt       = perf_if_cnt_q;
  assign perf_d_cnt        = perf_d_cnt_q;
  assign perf_conflict_cnt = perf_conflict_cnt_q;
`endif

endmodule
